// File: rtl/cic_comb_decimator.sv
// cic_comb_decimator
//   Comb (differentiator) half of a CIC decimator. Every DECIM-th input
//   strobe is captured, pushed through STAGES pipelined comb stages
//   (differential delay 1) and emitted, arithmetically scaled down to OW
//   bits, together with a one-cycle o_ready strobe.
//
// Parameters
//   IW      internal/input width (must match the integrator output width)
//   OW      output width, OW <= IW
//   DECIM   decimation ratio R, >= 1
//   STAGES  number of comb stages N, >= 1
//
// Ports
//   i_clk      system clock
//   i_reset_n  asynchronous reset, active low
//   i_ce       input sample strobe from the integrator chain
//   i_data     signed integrator output
//   o_data     signed decimated, filtered sample
//   o_ready    one-cycle strobe, o_data updated this cycle
//
// All arithmetic wraps modulo 2^IW on purpose: the comb differences cancel
// the wrap-around of the integrators, so no saturation is applied.
module cic_comb_decimator #(
    parameter int unsigned IW     = 12,
    parameter int unsigned OW     = 12,
    parameter int unsigned DECIM  = 4,
    parameter int unsigned STAGES = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_ce,
    input  logic signed [IW-1:0] i_data,
    output logic signed [OW-1:0] o_data,
    output logic                 o_ready
);

    localparam int unsigned CW    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
    localparam int unsigned SHIFT = IW - OW;

    logic [CW-1:0] cnt;

    // diff[0] is the captured decimated sample; diff[k] is comb stage k.
    logic signed [IW-1:0] diff [0:STAGES];
    logic signed [IW-1:0] dly  [1:STAGES];
    logic                 vld  [0:STAGES];

    // Decimation counter and stage-0 capture.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt     <= '0;
            diff[0] <= '0;
            vld[0]  <= 1'b0;
        end else begin
            vld[0] <= 1'b0;
            if (i_ce) begin
                if (cnt == CNT_LAST) begin
                    cnt     <= '0;
                    diff[0] <= i_data;
                    vld[0]  <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Comb stages: each advances only when the stage before it was valid,
    // so diff/dly hold between decimated samples.
    for (genvar k = 1; k <= STAGES; k++) begin : g_comb
        always_ff @(posedge i_clk or negedge i_reset_n) begin
            if (!i_reset_n) begin
                diff[k] <= '0;
                dly[k]  <= '0;
                vld[k]  <= 1'b0;
            end else begin
                vld[k] <= vld[k-1];
                if (vld[k-1]) begin
                    diff[k] <= diff[k-1] - dly[k];
                    dly[k]  <= diff[k-1];
                end
            end
        end
    end

    // Output register: arithmetic shift keeps the sign, then truncate to OW.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_data  <= '0;
            o_ready <= 1'b0;
        end else begin
            o_ready <= vld[STAGES];
            if (vld[STAGES]) begin
                o_data <= OW'(diff[STAGES] >>> SHIFT);
            end
        end
    end

endmodule

// File: tb/tb_cic_comb_decimator.sv
module tb_cic_comb_decimator;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic i_reset_n = 1'b1;

    // u_a: defaults (DECIM=4, STAGES=3); u_w: STAGES=1; u_t: DECIM=1, STAGES=2
    logic        ce_a = 1'b0, ce_w = 1'b0, ce_t = 1'b0;
    logic [11:0] d_a = '0, d_w = '0, d_t = '0;
    logic [11:0] o_a, o_w, o_t;
    logic        r_a, r_w, r_t;

    cic_comb_decimator #(.IW(12), .OW(12), .DECIM(4), .STAGES(3)) u_a (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(ce_a), .i_data(d_a),
        .o_data(o_a), .o_ready(r_a));

    cic_comb_decimator #(.IW(12), .OW(12), .DECIM(4), .STAGES(1)) u_w (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(ce_w), .i_data(d_w),
        .o_data(o_w), .o_ready(r_w));

    cic_comb_decimator #(.IW(12), .OW(12), .DECIM(1), .STAGES(2)) u_t (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_ce(ce_t), .i_data(d_t),
        .o_data(o_t), .o_ready(r_t));

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Output monitors: record the cycle number and value of every strobe.
    int          qc_a[$], qc_w[$], qc_t[$];
    logic [11:0] qd_a[$], qd_w[$], qd_t[$];

    always @(negedge i_clk) begin
        if (r_a) begin qc_a.push_back(cyc); qd_a.push_back(o_a); end
        if (r_w) begin qc_w.push_back(cyc); qd_w.push_back(o_w); end
        if (r_t) begin qc_t.push_back(cyc); qd_t.push_back(o_t); end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_queues();
        qc_a.delete(); qd_a.delete();
        qc_w.delete(); qd_w.delete();
        qc_t.delete(); qd_t.delete();
    endtask

    task automatic do_reset();
        ce_a = 1'b0; ce_w = 1'b0; ce_t = 1'b0;
        d_a = '0; d_w = '0; d_t = '0;
        i_reset_n = 1'b0;
        tick();
        tick();
        i_reset_n = 1'b1;
        tick();
        clear_queues();
    endtask

    // N-th order finite difference of the decimated sequence, with zero
    // history before the first sample, reduced modulo 2^12.
    function automatic logic [11:0] comb_ref(input int n, input logic [11:0] ys[$], input int idx);
        int acc = 0;
        int c   = 1;
        for (int j = 0; j <= n; j++) begin
            if (idx - j >= 0)
                acc += ((j % 2) != 0 ? -c : c) * int'(ys[idx - j]);
            c = c * (n - j) / (j + 1);
        end
        return 12'(acc);
    endfunction

    task automatic test_reset();
        i_reset_n = 1'b1;
        #1;
        i_reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ce_a = 1'($urandom); d_a = 12'($urandom);
            ce_w = 1'($urandom); d_w = 12'($urandom);
            ce_t = 1'($urandom); d_t = 12'($urandom);
            tick();
            checks++;
            if ({o_a, r_a, o_w, r_w, o_t, r_t} !== '0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got o_a=%h r_a=%b o_w=%h r_w=%b o_t=%h r_t=%b want all 0",
                         cyc, o_a, r_a, o_w, r_w, o_t, r_t);
            end
        end
        ce_a = 1'b0; ce_w = 1'b0; ce_t = 1'b0;
        i_reset_n = 1'b1;
        clear_queues();
        for (int i = 0; i < 100; i++) tick();
        checks++;
        if (qc_a.size() + qc_w.size() + qc_t.size() != 0) begin
            failures++;
            $display("FAIL reset_idle got %0d/%0d/%0d strobes want 0",
                     qc_a.size(), qc_w.size(), qc_t.size());
        end
    endtask

    task automatic test_count();
        logic [11:0] ys[$];
        int          ecap[$];
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            int gap = int'($urandom_range(0, 3));
            ce_a = 1'b0;
            for (int g = 0; g < gap; g++) tick();
            ce_a = 1'b1;
            d_a  = 12'($urandom);
            tick();
            if (k % 4 == 0) begin
                ys.push_back(d_a);
                ecap.push_back(cyc);
            end
        end
        ce_a = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (qc_a.size() != 5) begin
            failures++;
            $display("FAIL count_pulses got %0d want 5", qc_a.size());
        end
        for (int i = 0; i < 5 && i < qc_a.size(); i++) begin
            checks++;
            if (qc_a[i] !== ecap[i] + 4) begin
                failures++;
                $display("FAIL count_latency[%0d] got cyc=%0d want %0d", i, qc_a[i], ecap[i] + 4);
            end
            checks++;
            if (qd_a[i] !== comb_ref(3, ys, i)) begin
                failures++;
                $display("FAIL count_data[%0d] got %h want %h", i, qd_a[i], comb_ref(3, ys, i));
            end
        end
    endtask

    task automatic test_wrap();
        logic [11:0] ys[$];
        int          ecap[$];
        logic [11:0] val = 12'd2040;
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            int gap = int'($urandom_range(0, 2));
            ce_w = 1'b0;
            for (int g = 0; g < gap; g++) tick();
            ce_w = 1'b1;
            d_w  = val;
            tick();
            if (k % 4 == 0) begin
                ys.push_back(d_w);
                ecap.push_back(cyc);
            end
            val = val + 12'd1;
        end
        ce_w = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (qc_w.size() != 6) begin
            failures++;
            $display("FAIL wrap_pulses got %0d want 6", qc_w.size());
        end
        for (int i = 0; i < 6 && i < qc_w.size(); i++) begin
            logic [11:0] want = (i == 0) ? ys[0] : 12'd4;
            checks++;
            if (qd_w[i] !== want || qc_w[i] !== ecap[i] + 2) begin
                failures++;
                $display("FAIL wrap_out[%0d] got %h@%0d want %h@%0d", i, qd_w[i], qc_w[i], want, ecap[i] + 2);
            end
        end
    endtask

    task automatic test_chain();
        logic [11:0] acc1, acc2, acc3;
        logic [11:0] x;
        logic [11:0] want;
        do_reset();
        acc1 = '0; acc2 = '0; acc3 = '0;
        for (int phase = 0; phase < 2; phase++) begin
            x    = (phase == 0) ? 12'd1 : 12'hFFF;
            want = (phase == 0) ? 12'd64 : 12'hFC0;
            clear_queues();
            for (int i = 0; i < 200; i++) begin
                acc1 = acc1 + x;
                acc2 = acc2 + acc1;
                acc3 = acc3 + acc2;
                ce_a = 1'b1;
                d_a  = acc3;
                tick();
            end
            ce_a = 1'b0;
            for (int i = 0; i < 6; i++) tick();
            checks++;
            if (qd_a.size() < 40) begin
                failures++;
                $display("FAIL chain_pulses[%0d] got %0d want >=40", phase, qd_a.size());
            end else begin
                for (int i = qd_a.size() - 5; i < qd_a.size(); i++) begin
                    checks++;
                    if (qd_a[i] !== want) begin
                        failures++;
                        $display("FAIL chain_steady[%0d][%0d] got %h want %h", phase, i, qd_a[i], want);
                    end
                end
            end
        end
    endtask

    task automatic test_throughput();
        logic [11:0] ys[$];
        int          ecap[$];
        do_reset();
        for (int n = 0; n < 40; n++) begin
            ce_t = 1'b1;
            d_t  = 12'(n * (n + 1) / 2);
            tick();
            ys.push_back(d_t);
            ecap.push_back(cyc);
        end
        ce_t = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (qc_t.size() != 40) begin
            failures++;
            $display("FAIL tput_pulses got %0d want 40", qc_t.size());
        end
        for (int i = 0; i < 40 && i < qc_t.size(); i++) begin
            logic [11:0] want = (i >= 2) ? 12'd1 : comb_ref(2, ys, i);
            checks++;
            if (qd_t[i] !== want || qc_t[i] !== ecap[i] + 3) begin
                failures++;
                $display("FAIL tput_out[%0d] got %h@%0d want %h@%0d", i, qd_t[i], qc_t[i], want, ecap[i] + 3);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [11:0] dnew;
        int          e2;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ce_a = 1'b1;
            d_a  = 12'($urandom);
            tick();
        end
        ce_a = 1'b0;
        tick();
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (qc_a.size() != 0) begin
            failures++;
            $display("FAIL midflight_drop got %0d strobes want 0", qc_a.size());
        end
        for (int k = 0; k < 3; k++) begin
            ce_a = 1'b1;
            d_a  = 12'($urandom);
            tick();
        end
        ce_a = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (qc_a.size() != 0) begin
            failures++;
            $display("FAIL midflight_early got %0d strobes want 0", qc_a.size());
        end
        dnew = 12'($urandom);
        ce_a = 1'b1;
        d_a  = dnew;
        tick();
        e2   = cyc;
        ce_a = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (qc_a.size() != 1) begin
            failures++;
            $display("FAIL midflight_pulses got %0d want 1", qc_a.size());
        end else begin
            checks++;
            if (qd_a[0] !== dnew || qc_a[0] !== e2 + 4) begin
                failures++;
                $display("FAIL midflight_out got %h@%0d want %h@%0d", qd_a[0], qc_a[0], dnew, e2 + 4);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_wrap();
        test_chain();
        test_throughput();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
